// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - four-way set-associative write-back write-allocate L1 cache
//
// 16 sets x 4 ways x 32-byte lines. tag = addr[31:9], set = addr[8:5],
// word = addr[4:2]. One outstanding CPU request at a time.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   ufp_addr/ufp_rmask/ufp_wmask/ufp_wdata : CPU request, held until ufp_resp
//   ufp_rdata/ufp_resp                     : CPU response (resp is a 1-cycle pulse)
//   dfp_addr/dfp_read/dfp_write/dfp_wdata  : line request to memory, held until dfp_resp
//   dfp_rdata/dfp_resp                     : line refill data and completion pulse
//
// Build option: CACHE_PLRU_EN selects 3-bit tree pseudo-LRU per set;
// otherwise true LRU with four 2-bit age ranks per set.
module l1_cache (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ufp_addr,
    input  logic [3:0]   ufp_rmask,
    input  logic [3:0]   ufp_wmask,
    input  logic [31:0]  ufp_wdata,
    output logic [31:0]  ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    output logic         dfp_write,
    output logic [255:0] dfp_wdata,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    state_t       state;

    logic [31:0]  req_addr;
    logic [3:0]   req_rmask;
    logic [3:0]   req_wmask;
    logic [31:0]  req_wdata;
    logic [1:0]   alloc_way;

    logic [255:0] data_q  [4][16];
    logic [22:0]  tag_q   [4][16];
    logic [15:0]  valid_q [4];
    logic [15:0]  dirty_q [4];

    // The lookup port looks at the live request while the cache can take a new
    // one (idle, or the cycle a hit response is out), and at the captured
    // request otherwise. This lets a hit answer in the cycle right after it is
    // sampled and a new request be sampled on the very next edge.
    logic         accept;
    logic [22:0]  lk_tag;
    logic [3:0]   lk_set;
    logic [2:0]   lk_word;
    logic [3:0]   lk_rmask;
    logic [3:0]   lk_wmask;
    logic [31:0]  lk_wdata;
    logic         lk_req;
    logic         lk_wr;

    assign accept   = (state == IDLE) || ((state == COMPARE) && ufp_resp);
    assign lk_tag   = accept ? ufp_addr[31:9] : req_addr[31:9];
    assign lk_set   = accept ? ufp_addr[8:5]  : req_addr[8:5];
    assign lk_word  = accept ? ufp_addr[4:2]  : req_addr[4:2];
    assign lk_rmask = accept ? ufp_rmask      : req_rmask;
    assign lk_wmask = accept ? ufp_wmask      : req_wmask;
    assign lk_wdata = accept ? ufp_wdata      : req_wdata;
    assign lk_req   = (|lk_rmask) || (|lk_wmask);
    assign lk_wr    = |lk_wmask;

    logic         hit;
    logic [1:0]   hit_way;
    logic [255:0] hit_line;
    logic [31:0]  hit_word;
    logic [255:0] merged_line;
    logic         access_fire;

    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (valid_q[w][lk_set] && (tag_q[w][lk_set] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    assign hit_line = data_q[hit_way][lk_set];
    assign hit_word = hit_line[{lk_word, 5'b00000} +: 32];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (lk_wmask[b]) begin
                merged_line[{lk_word, 2'(b), 3'b000} +: 8] = lk_wdata[b*8 +: 8];
            end
        end
    end

    // REFILL always hits: the line was installed on the previous edge.
    assign access_fire = hit && ((accept && lk_req) || (state == REFILL));

    logic [1:0] repl_victim;
    logic [1:0] victim_way;

`ifdef CACHE_PLRU_EN
    // bit 2: victim half (0 = ways 0/1), bit 1: victim in ways 0/1,
    // bit 0: victim in ways 2/3. Each bit points away from the last use.
    logic [2:0] plru_q [16];
    logic [2:0] plru_next;

    always_comb begin
        plru_next    = plru_q[lk_set];
        plru_next[2] = ~hit_way[1];
        if (hit_way[1]) begin
            plru_next[0] = ~hit_way[0];
        end else begin
            plru_next[1] = ~hit_way[0];
        end
        repl_victim = {plru_q[lk_set][2],
                       plru_q[lk_set][2] ? plru_q[lk_set][0] : plru_q[lk_set][1]};
    end
`else
    // Age 0 = most recent. Ways at or below the accessed way's age step up by
    // one (saturating), which also turns the all-zero reset ranks into a
    // proper permutation as ways get used.
    logic [1:0] age_q    [4][16];
    logic [1:0] age_next [4];
    logic [1:0] oldest;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            age_next[j] = age_q[j][lk_set];
            if (2'(j) == hit_way) begin
                age_next[j] = 2'd0;
            end else if ((age_q[j][lk_set] <= age_q[hit_way][lk_set]) &&
                         (age_q[j][lk_set] != 2'd3)) begin
                age_next[j] = age_q[j][lk_set] + 2'd1;
            end
        end
        oldest = 2'd0;
        for (int w = 1; w < 4; w++) begin
            if (age_q[w][lk_set] > age_q[oldest][lk_set]) begin
                oldest = 2'(w);
            end
        end
        repl_victim = oldest;
    end
`endif

    // Lowest-index invalid way wins over the replacement policy.
    always_comb begin
        victim_way = repl_victim;
        for (int w = 3; w >= 0; w--) begin
            if (!valid_q[w][lk_set]) begin
                victim_way = 2'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_rmask <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
            alloc_way <= '0;
            ufp_resp  <= 1'b0;
            ufp_rdata <= '0;
            dfp_addr  <= '0;
            dfp_read  <= 1'b0;
            dfp_write <= 1'b0;
            dfp_wdata <= '0;
            for (int w = 0; w < 4; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
`ifdef CACHE_PLRU_EN
            for (int s = 0; s < 16; s++) begin
                plru_q[s] <= '0;
            end
`else
            for (int w = 0; w < 4; w++) begin
                for (int s = 0; s < 16; s++) begin
                    age_q[w][s] <= '0;
                end
            end
`endif
        end else begin
            ufp_resp <= 1'b0;

            if (access_fire) begin
                ufp_resp <= 1'b1;
                if (lk_wr) begin
                    dirty_q[hit_way][lk_set] <= 1'b1;
                end else begin
                    ufp_rdata <= hit_word;
                end
`ifdef CACHE_PLRU_EN
                plru_q[lk_set] <= plru_next;
`else
                for (int j = 0; j < 4; j++) begin
                    age_q[j][lk_set] <= age_next[j];
                end
`endif
            end

            case (state)
                IDLE, COMPARE: begin
                    if ((state == COMPARE) && !ufp_resp) begin
                        // Miss cycle: lookup fields come from the captured request.
                        alloc_way <= victim_way;
                        if (valid_q[victim_way][lk_set] && dirty_q[victim_way][lk_set]) begin
                            dfp_write <= 1'b1;
                            dfp_addr  <= {tag_q[victim_way][lk_set], lk_set, 5'b00000};
                            dfp_wdata <= data_q[victim_way][lk_set];
                            state     <= WRITEBACK;
                        end else begin
                            dfp_read  <= 1'b1;
                            dfp_addr  <= req_addr & 32'hFFFF_FFE0;
                            state     <= ALLOCATE;
                        end
                    end else if (lk_req) begin
                        req_addr  <= ufp_addr;
                        req_rmask <= ufp_rmask;
                        req_wmask <= ufp_wmask;
                        req_wdata <= ufp_wdata;
                        state     <= COMPARE;
                    end else begin
                        state     <= IDLE;
                    end
                end
                WRITEBACK: begin
                    if (dfp_resp) begin
                        dfp_write <= 1'b0;
                        dfp_read  <= 1'b1;
                        dfp_addr  <= req_addr & 32'hFFFF_FFE0;
                        state     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (dfp_resp) begin
                        dfp_read <= 1'b0;
                        valid_q[alloc_way][req_addr[8:5]] <= 1'b1;
                        dirty_q[alloc_way][req_addr[8:5]] <= 1'b0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    state <= COMPARE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if ((state == ALLOCATE) && dfp_resp) begin
            data_q[alloc_way][req_addr[8:5]] <= dfp_rdata;
            tag_q[alloc_way][req_addr[8:5]]  <= req_addr[31:9];
        end else if (access_fire && lk_wr) begin
            data_q[hit_way][lk_set] <= merged_line;
        end
    end

endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - directed self-checking bench for l1_cache
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  ufp_addr = '0;
    logic [3:0]   ufp_rmask = '0;
    logic [3:0]   ufp_wmask = '0;
    logic [31:0]  ufp_wdata = '0;
    logic [31:0]  ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata = '0;
    logic         dfp_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    l1_cache dut (
        .clk       (clk),
        .rst       (rst),
        .ufp_addr  (ufp_addr),
        .ufp_rmask (ufp_rmask),
        .ufp_wmask (ufp_wmask),
        .ufp_wdata (ufp_wdata),
        .ufp_rdata (ufp_rdata),
        .ufp_resp  (ufp_resp),
        .dfp_addr  (dfp_addr),
        .dfp_read  (dfp_read),
        .dfp_write (dfp_write),
        .dfp_wdata (dfp_wdata),
        .dfp_rdata (dfp_rdata),
        .dfp_resp  (dfp_resp)
    );

    always #5 clk = ~clk;

    // Memory: every word of line A holds the nibble A[12:9] replicated.
    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [3:0] n;
        n = a[12:9];
        line_pat = {64{n}};
    endfunction

    // Memory model: answers 3 cycles after a request appears, logs traffic.
    int          mcnt = 0;
    int          evt = 0;
    int          rd_evt = 0;
    int          wr_evt = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          both_count = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (dfp_read && dfp_write) both_count++;
        if (dfp_resp) begin
            dfp_resp = 1'b0;
            mcnt = 0;
        end else if (dfp_read || dfp_write) begin
            mcnt++;
            if (mcnt == 1) begin
                evt++;
                if (dfp_write) begin
                    wr_count++;
                    wr_evt = evt;
                    last_wr_addr = dfp_addr;
                    last_wr_data = dfp_wdata;
                end else begin
                    rd_count++;
                    rd_evt = evt;
                    last_rd_addr = dfp_addr;
                end
            end
            if (mcnt == 3) begin
                dfp_resp = 1'b1;
                dfp_rdata = line_pat(dfp_addr);
            end
        end else begin
            mcnt = 0;
        end
    end

    // One request; cyc counts negedges from issue until ufp_resp is seen.
    task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd, output int cyc, output logic [31:0] rd);
        @(negedge clk);
        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ufp_resp && cyc < 200);
        rd = ufp_rdata;
        ufp_rmask = '0; ufp_wmask = '0;
        checks++;
        if (!ufp_resp) begin
            errors++;
            $display("FAIL resp_timeout addr=%h: got no ufp_resp, expected one within 200 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (ufp_resp !== 1'b0)   begin errors++; $display("FAIL reset_ufp_resp: got %b expected 0", ufp_resp); end
        if (ufp_rdata !== 32'h0) begin errors++; $display("FAIL reset_ufp_rdata: got %h expected 0", ufp_rdata); end
        if (dfp_read !== 1'b0)   begin errors++; $display("FAIL reset_dfp_read: got %b expected 0", dfp_read); end
        if (dfp_write !== 1'b0)  begin errors++; $display("FAIL reset_dfp_write: got %b expected 0", dfp_write); end
        if (dfp_addr !== 32'h0)  begin errors++; $display("FAIL reset_dfp_addr: got %h expected 0", dfp_addr); end
        if (dfp_wdata !== 256'h0) begin errors++; $display("FAIL reset_dfp_wdata: got %h expected 0", dfp_wdata); end
        rst = 1'b1;
    endtask

    task automatic test_cold_reads();
        int cyc; logic [31:0] rd; logic [31:0] a; logic [3:0] n; int rd0;
        for (int i = 0; i < 4; i++) begin
            a = 32'(i) * 32'h200;
            n = 4'(i);
            rd0 = rd_count;
            do_req(a, 4'hF, 4'h0, 32'h0, cyc, rd);
            checks += 4;
            if (cyc !== 6) begin errors++; $display("FAIL cold_latency %h: got %0d expected 6", a, cyc); end
            if (rd_count - rd0 !== 1) begin errors++; $display("FAIL cold_dfp_read %h: got %0d reads expected 1", a, rd_count - rd0); end
            if (last_rd_addr !== a) begin errors++; $display("FAIL cold_dfp_addr: got %h expected %h", last_rd_addr, a); end
            if (rd !== {8{n}}) begin errors++; $display("FAIL cold_data %h: got %h expected %h", a, rd, {8{n}}); end
        end
    endtask

    task automatic test_hits();
        logic [31:0] addrs [6];
        int cyc; logic [31:0] rd; int traffic0; logic [3:0] n;
        addrs = '{32'h000, 32'h200, 32'h400, 32'h600, 32'h400, 32'h000};
        for (int i = 0; i < 6; i++) begin
            traffic0 = rd_count + wr_count;
            n = addrs[i][12:9];
            do_req(addrs[i], 4'hF, 4'h0, 32'h0, cyc, rd);
            checks += 3;
            if (cyc !== 1) begin errors++; $display("FAIL hit_latency %h: got %0d expected 1", addrs[i], cyc); end
            if (rd !== {8{n}}) begin errors++; $display("FAIL hit_data %h: got %h expected %h", addrs[i], rd, {8{n}}); end
            if (rd_count + wr_count !== traffic0) begin errors++; $display("FAIL hit_traffic %h: got %0d dfp requests expected 0", addrs[i], rd_count + wr_count - traffic0); end
        end
    endtask

    // Recency after test_hits, newest first: 0x000, 0x400, 0x600, 0x200.
    task automatic test_lru_evict();
        int cyc; logic [31:0] rd; int wr0;
        wr0 = wr_count;
        do_req(32'h800, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks += 3;
        if (cyc !== 6) begin errors++; $display("FAIL lru_800_latency: got %0d expected 6", cyc); end
        if (rd !== 32'h44444444) begin errors++; $display("FAIL lru_800_data: got %h expected 44444444", rd); end
        if (wr_count !== wr0) begin errors++; $display("FAIL lru_800_clean: got %0d writes expected 0", wr_count - wr0); end
        // 0x200 was the LRU line, so it must miss again.
        do_req(32'h200, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks += 2;
        if (cyc !== 6) begin errors++; $display("FAIL lru_200_latency: got %0d expected 6", cyc); end
        if (rd !== 32'h11111111) begin errors++; $display("FAIL lru_200_data: got %h expected 11111111", rd); end
        do_req(32'h000, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL lru_000_hit: got %0d cycles expected 1", cyc); end
        do_req(32'h800, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL lru_800_hit: got %0d cycles expected 1", cyc); end
    endtask

    task automatic test_write_hit();
        int cyc; logic [31:0] rd; int traffic0;
        traffic0 = rd_count + wr_count;
        do_req(32'h404, 4'h0, 4'b0011, 32'hDEADBEEF, cyc, rd);
        checks += 3;
        if (cyc !== 1) begin errors++; $display("FAIL write_latency: got %0d expected 1", cyc); end
        if (rd !== 32'h44444444) begin errors++; $display("FAIL write_rdata_held: got %h expected 44444444", rd); end
        if (rd_count + wr_count !== traffic0) begin errors++; $display("FAIL write_traffic: got %0d dfp requests expected 0", rd_count + wr_count - traffic0); end
        do_req(32'h404, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks += 2;
        if (cyc !== 1) begin errors++; $display("FAIL merged_latency: got %0d expected 1", cyc); end
        if (rd !== 32'h2222BEEF) begin errors++; $display("FAIL merged_data: got %h expected 2222beef", rd); end
        do_req(32'h400, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks++;
        if (rd !== 32'h22222222) begin errors++; $display("FAIL neighbour_word: got %h expected 22222222", rd); end
    endtask

    task automatic test_dirty_evict();
        int cyc; logic [31:0] rd; int wr0; int rd0; logic [255:0] exp_line;
        exp_line = line_pat(32'h400);
        exp_line[63:32] = 32'h2222BEEF;
        // Touch the other three ways so the dirty 0x400 line becomes LRU.
        do_req(32'h000, 4'hF, 4'h0, 32'h0, cyc, rd);
        do_req(32'h800, 4'hF, 4'h0, 32'h0, cyc, rd);
        do_req(32'h200, 4'hF, 4'h0, 32'h0, cyc, rd);
        wr0 = wr_count; rd0 = rd_count;
        do_req(32'hA00, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks += 8;
        if (cyc !== 10) begin errors++; $display("FAIL evict_latency: got %0d expected 10", cyc); end
        if (wr_count - wr0 !== 1) begin errors++; $display("FAIL evict_write_count: got %0d expected 1", wr_count - wr0); end
        if (rd_count - rd0 !== 1) begin errors++; $display("FAIL evict_read_count: got %0d expected 1", rd_count - rd0); end
        if (last_wr_addr !== 32'h400) begin errors++; $display("FAIL evict_wr_addr: got %h expected 00000400", last_wr_addr); end
        if (last_wr_data !== exp_line) begin errors++; $display("FAIL evict_wr_data: got %h expected %h", last_wr_data, exp_line); end
        if (!(wr_evt < rd_evt)) begin errors++; $display("FAIL evict_order: got write event %0d read event %0d expected write first", wr_evt, rd_evt); end
        if (last_rd_addr !== 32'hA00) begin errors++; $display("FAIL evict_rd_addr: got %h expected 00000a00", last_rd_addr); end
        if (rd !== 32'h55555555) begin errors++; $display("FAIL evict_data: got %h expected 55555555", rd); end
        checks++;
        if (both_count !== 0) begin errors++; $display("FAIL read_write_overlap: got %0d cycles expected 0", both_count); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        ufp_addr = 32'hA04; ufp_rmask = 4'hF; ufp_wmask = 4'h0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!ufp_resp && cyc < 50);
        checks += 2;
        if (cyc !== 1) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 1", cyc); end
        if (ufp_rdata !== 32'h55555555) begin errors++; $display("FAIL b2b_first_data: got %h expected 55555555", ufp_rdata); end
        // Present the next request during the response cycle.
        ufp_addr = 32'h000;
        @(negedge clk);
        checks += 2;
        if (ufp_resp !== 1'b1) begin errors++; $display("FAIL b2b_second_resp: got %b expected 1", ufp_resp); end
        if (ufp_rdata !== 32'h00000000) begin errors++; $display("FAIL b2b_second_data: got %h expected 00000000", ufp_rdata); end
        ufp_rmask = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int waited; int cyc; logic [31:0] rd; int rd0;
        @(negedge clk);
        ufp_addr = 32'hC00; ufp_rmask = 4'hF; ufp_wmask = 4'h0;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!dfp_read && waited < 20);
        checks++;
        if (dfp_read !== 1'b1) begin errors++; $display("FAIL mid_alloc_reached: got dfp_read=%b expected 1", dfp_read); end
        rst = 1'b0;
        #1;
        checks += 3;
        if (dfp_read !== 1'b0) begin errors++; $display("FAIL mid_dfp_read_drop: got %b expected 0", dfp_read); end
        if (dfp_addr !== 32'h0) begin errors++; $display("FAIL mid_dfp_addr: got %h expected 0", dfp_addr); end
        if (ufp_resp !== 1'b0) begin errors++; $display("FAIL mid_ufp_resp: got %b expected 0", ufp_resp); end
        ufp_rmask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd0 = rd_count;
        do_req(32'h000, 4'hF, 4'h0, 32'h0, cyc, rd);
        checks += 3;
        if (cyc !== 6) begin errors++; $display("FAIL post_reset_miss_latency: got %0d expected 6", cyc); end
        if (rd_count - rd0 !== 1) begin errors++; $display("FAIL post_reset_refill: got %0d reads expected 1", rd_count - rd0); end
        if (rd !== 32'h00000000) begin errors++; $display("FAIL post_reset_data: got %h expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_cold_reads();
        test_hits();
        test_lru_evict();
        test_write_hit();
        test_dirty_evict();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
